// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the Wishbone-to-async-SRAM controller.
// The optional wait state (SRAM_CTRL_WAIT_STATE_EN) adds READ_W / WRITE_W to the sequence.
package sram_ctrl_pkg;

    localparam int SRAM_BYTES      = 4;
    localparam int SRAM_BYTE_WIDTH = $clog2(SRAM_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        READ,
        READ_W,
        READ_2,
        WRITE,
        WRITE_2,
        WRITE_W,
        WRITE_3,
        DONE
    } state_e;

    // Number of address bits that select a byte inside one data word
    function automatic int lane_bits(input int width);
        return $clog2(width / 8);
    endfunction

endpackage

// File: rtl/sram_data_iobuf.sv
// Tristate driver for the shared SRAM data bus; the bus is released whenever
// drive_en is low, and the pad value is always visible on data_in.
module sram_data_iobuf #(
    parameter int WIDTH = 32
) (
    inout  wire  [WIDTH-1:0] pad,
    input  logic             drive_en,
    input  logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] data_in
);

    assign pad     = drive_en ? data_out : {WIDTH{1'bz}};
    assign data_in = pad;

endmodule

// File: rtl/sram_controller.sv
// Wishbone B4 classic slave running one async-SRAM read or write per bus cycle.
// Build option: define SRAM_CTRL_WAIT_STATE_EN to stretch each access by one cycle.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int SRAM_DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    output logic                         wb_ack_o,
    input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
    input  logic                         wb_we_i,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    inout  wire  [SRAM_DATA_WIDTH-1:0]   sram_data,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

    localparam int LANES    = SRAM_DATA_WIDTH / 8;
    localparam int ADDR_LSB = lane_bits(SRAM_DATA_WIDTH);

    state_e                       state_reg, state_next;
    logic                         ce_n_reg, ce_n_next;
    logic                         oe_n_reg, oe_n_next;
    logic                         we_n_reg, we_n_next;
    logic [LANES-1:0]             be_n_reg, be_n_next;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [SRAM_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic                         drive_reg, drive_next;
    logic                         ack_reg, ack_next;
    logic [DATA_WIDTH-1:0]        rdata_reg, rdata_next;
    logic [SRAM_DATA_WIDTH-1:0]   sram_din;

    // Byte-offset and out-of-range address bits are intentionally ignored
    logic unused_adr_bits;
    assign unused_adr_bits = ^wb_adr_i;

    sram_data_iobuf #(
        .WIDTH(SRAM_DATA_WIDTH)
    ) u_iobuf (
        .pad     (sram_data),
        .drive_en(drive_reg),
        .data_out(wdata_reg),
        .data_in (sram_din)
    );

    always_comb begin
        state_next = state_reg;
        ce_n_next  = ce_n_reg;
        oe_n_next  = oe_n_reg;
        we_n_next  = we_n_reg;
        be_n_next  = be_n_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        drive_next = drive_reg;
        ack_next   = 1'b0;
        rdata_next = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    addr_next  = wb_adr_i[ADDR_LSB +: SRAM_ADDR_WIDTH];
                    be_n_next  = ~wb_sel_i;
                    wdata_next = wb_dat_i;
                    ce_n_next  = 1'b0;
                    if (wb_we_i) begin
                        // Data goes out now; we_n falls one cycle later so data is settled first
                        drive_next = 1'b1;
                        state_next = WRITE;
                    end else begin
                        oe_n_next  = 1'b0;
                        state_next = READ;
                    end
                end
            end
            READ: begin
`ifdef SRAM_CTRL_WAIT_STATE_EN
                state_next = READ_W;
`else
                state_next = READ_2;
`endif
            end
            READ_W: begin
                state_next = READ_2;
            end
            READ_2: begin
                rdata_next = sram_din;
                ack_next   = 1'b1;
                ce_n_next  = 1'b1;
                oe_n_next  = 1'b1;
                be_n_next  = '1;
                state_next = DONE;
            end
            WRITE: begin
                we_n_next  = 1'b0;
                state_next = WRITE_2;
            end
            WRITE_2: begin
`ifdef SRAM_CTRL_WAIT_STATE_EN
                state_next = WRITE_W;
`else
                we_n_next  = 1'b1;
                state_next = WRITE_3;
`endif
            end
            WRITE_W: begin
                we_n_next  = 1'b1;
                state_next = WRITE_3;
            end
            WRITE_3: begin
                // we_n rose a cycle ago, so releasing data here keeps hold time
                ack_next   = 1'b1;
                ce_n_next  = 1'b1;
                drive_next = 1'b0;
                be_n_next  = '1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            be_n_reg  <= '1;
            addr_reg  <= '0;
            wdata_reg <= '0;
            drive_reg <= 1'b0;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ce_n_reg  <= ce_n_next;
            oe_n_reg  <= oe_n_next;
            we_n_reg  <= we_n_next;
            be_n_reg  <= be_n_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            drive_reg <= drive_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
        end
    end

    assign wb_ack_o  = ack_reg;
    assign wb_dat_o  = rdata_reg;
    assign sram_addr = addr_reg;
    assign sram_ce_n = ce_n_reg;
    assign sram_oe_n = oe_n_reg;
    assign sram_we_n = we_n_reg;
    assign sram_be_n = be_n_reg;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural async SRAM model.
// Honours SRAM_CTRL_WAIT_STATE_EN when the design is built with it.
module tb_sram_controller;
    import sram_ctrl_pkg::*;

`ifdef SRAM_CTRL_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic                      clk_i;
    logic                      rst_ni;
    logic                      wb_cyc_i;
    logic                      wb_stb_i;
    logic                      wb_ack_o;
    logic [31:0]               wb_adr_i;
    logic [31:0]               wb_dat_i;
    logic [31:0]               wb_dat_o;
    logic [SRAM_BYTES-1:0]     wb_sel_i;
    logic                      wb_we_i;
    logic [19:0]               sram_addr;
    wire  [31:0]               sram_data;
    logic                      sram_ce_n;
    logic                      sram_oe_n;
    logic                      sram_we_n;
    logic [SRAM_BYTES-1:0]     sram_be_n;

    int errors = 0;
    int checks = 0;

    sram_controller dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .sram_addr(sram_addr),
        .sram_data(sram_data),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_be_n(sram_be_n)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Async SRAM model: drives on read, commits on the rising edge of we_n
    bit [31:0] mem [0:1048575];
    logic model_drive;
    assign model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_data   = model_drive ? mem[sram_addr] : 32'hzzzz_zzzz;

    always @(posedge sram_we_n) begin
        if (rst_ni && !sram_ce_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr][b*8 +: 8] = sram_data[b*8 +: 8];
            end
        end
    end

    // Protocol monitor sampled mid-cycle
    int          viol = 0;
    logic        prev_ce_n = 1'b1;
    logic        prev_we_n = 1'b1;
    logic        prev_ack  = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [3:0]  prev_be_n = '1;
    logic [31:0] prev_data = '0;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (!sram_ce_n && !prev_ce_n &&
                (sram_addr != prev_addr || sram_be_n != prev_be_n || sram_data != prev_data))
                viol = viol + 1;
            if (!sram_we_n && prev_we_n && prev_ce_n) viol = viol + 1;
            if (!sram_we_n && !sram_oe_n) viol = viol + 1;
            if (wb_ack_o && prev_ack) viol = viol + 1;
        end
        prev_ce_n = sram_ce_n;
        prev_we_n = sram_we_n;
        prev_ack  = wb_ack_o;
        prev_addr = sram_addr;
        prev_be_n = sram_be_n;
        prev_data = sram_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit drop, input bit keep,
                           output int wait_e, output int lat, output int oe_c, output int we_c,
                           output logic [19:0] a, output logic [3:0] ben,
                           output logic [31:0] rd, output bit ack_one);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wait_e = 0;
        do begin
            @(posedge clk_i); #1;
            wait_e++;
        end while (sram_ce_n && wait_e < 20);
        a    = sram_addr;
        ben  = sram_be_n;
        lat  = 0;
        oe_c = sram_oe_n ? 0 : 1;
        we_c = sram_we_n ? 0 : 1;
        if (drop) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
        while (!wb_ack_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
            if (!sram_oe_n) oe_c++;
            if (!sram_we_n) we_c++;
        end
        rd = wb_dat_o;
        if (!keep) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
        end
        @(posedge clk_i); #1;
        ack_one = !wb_ack_o && sram_ce_n;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          drop;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    task automatic apply(input string tag, input vec_t v, input bit keep);
        int wait_e, lat, oe_c, we_c;
        logic [19:0] a;
        logic [3:0]  ben;
        logic [31:0] rd;
        bit          ack_one;
        run_txn(v.we, v.adr, v.dat, v.sel, v.drop, keep, wait_e, lat, oe_c, we_c, a, ben, rd, ack_one);
        $display("%s %s adr=%h dat=%h sel=%h -> addr=%h be_n=%b lat=%0d oe=%0d we=%0d rd=%h",
                 tag, v.we ? "WR" : "RD", v.adr, v.dat, v.sel, a, ben, lat, oe_c, we_c, rd);
        check({tag, " accept"}, wait_e, 1);
        check({tag, " sram_addr"}, a, v.exp_addr);
        check({tag, " be_n"}, ben, v.exp_be_n);
        check({tag, " ack_latency"}, lat, v.we ? 3 + WS : 2 + WS);
        check({tag, " oe_low_cycles"}, oe_c, v.we ? 0 : 2 + WS);
        check({tag, " we_low_cycles"}, we_c, v.we ? 1 + WS : 0);
        check({tag, " ack_one_cycle_then_idle"}, ack_one, 1);
        if (!v.we) check({tag, " rdata"}, rd, v.exp_rd);
    endtask

    initial begin
        bit ack_seen;
        vec_t v;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 20'h00004, 4'b0000, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 20'h00004, 4'b0000, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'hAA00_0000, 4'h8, 1'b0, 20'h00004, 4'b0111, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 20'h00004, 4'b0000, 32'hAAAD_BEEF};
        vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0000_5566, 4'h3, 1'b1, 20'h00008, 4'b1100, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, 20'h00008, 4'b1111, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 20'h00008, 4'b0000, 32'h0000_5566};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 4'hF, 1'b0, 20'hFFFFF, 4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 32'h003F_FFFC, 32'h0,         4'hF, 1'b0, 20'hFFFFF, 4'b0000, 32'h0BAD_F00D};
        vecs[9]  = '{1'b0, 32'h0040_0010, 32'h0,         4'hF, 1'b0, 20'h00004, 4'b0000, 32'hAAAD_BEEF};
        vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 20'h00008, 4'b1111, 32'h0000_5566};

        rst_ni   = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset strobes ce/oe/we", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check("reset be_n", sram_be_n, 4'hF);
        check("reset sram_addr", sram_addr, 20'h0);
        check("reset ack", wb_ack_o, 1'b0);
        check("reset dat_o", wb_dat_o, 32'h0);
        $display("reset: ce_n=%b oe_n=%b we_n=%b be_n=%b addr=%h", sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 11; i++) apply($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Reset asserted while we_n is low: write must be abandoned
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h10; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF;
        @(posedge clk_i); #1;
        check("abort accepted", sram_ce_n, 1'b0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort we_n low in WRITE_2", sram_we_n, 1'b0);
        rst_ni = 1'b0;
        #1;
        check("abort strobes released", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (wb_ack_o) ack_seen = 1'b1;
        end
        check("abort no ack", ack_seen, 1'b0);
        $display("abort: ce_n=%b we_n=%b ack_seen=%b", sram_ce_n, sram_we_n, ack_seen);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        v = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 20'h00004, 4'b0000, 32'hAAAD_BEEF};
        apply("post_abort", v, 1'b0);

        // Back-to-back with strobe held through ack
        v = '{1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, 20'h00008, 4'b0000, 32'h0000_5566};
        apply("b2b0", v, 1'b1);
        v = '{1'b1, 32'h0000_0024, 32'h0000_0077, 4'hF, 1'b0, 20'h00009, 4'b0000, 32'h0};
        apply("b2b1", v, 1'b1);
        v = '{1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b0, 20'h00009, 4'b0000, 32'h0000_0077};
        apply("b2b2", v, 1'b0);

        repeat (2) @(posedge clk_i);
        #1;
        check("protocol violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
